// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate scheduler and its laser tracker.
package parking_pkg;

    localparam int unsigned CNT_W = 7;

    localparam logic [1:0] L_NONE = 2'b00;
    localparam logic [1:0] L_OUT  = 2'b01;
    localparam logic [1:0] L_BOTH = 2'b11;
    localparam logic [1:0] L_IN   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        OPEN_IN,
        OPEN_OUT,
        CLOSE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        IN1,
        IN2,
        IN3,
        OUT1,
        OUT2,
        OUT3
    } trk_state_t;

endpackage

// File: rtl/parking_gate_scheduler_tracker.sv
// Follows the outer/inner laser pair and reports completed passes in either
// direction, or a car that backed out, as one-cycle registered pulses.
module laser_seq_tracker
    import parking_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] lasers,
    output logic       done_in,
    output logic       done_out,
    output logic       back
);

    trk_state_t state, state_n;
    logic       done_in_n, done_out_n, back_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= T_IDLE;
            done_in  <= 1'b0;
            done_out <= 1'b0;
            back     <= 1'b0;
        end else begin
            state    <= state_n;
            done_in  <= done_in_n;
            done_out <= done_out_n;
            back     <= back_n;
        end
    end

    // Non-adjacent codes leave the state untouched.
    always_comb begin
        state_n    = state;
        done_in_n  = 1'b0;
        done_out_n = 1'b0;
        back_n     = 1'b0;
        case (state)
            T_IDLE: begin
                if (lasers == L_OUT)      state_n = IN1;
                else if (lasers == L_IN)  state_n = OUT1;
            end
            IN1: begin
                if (lasers == L_BOTH)     state_n = IN2;
                else if (lasers == L_NONE) begin
                    back_n  = 1'b1;
                    state_n = T_IDLE;
                end
            end
            IN2: begin
                if (lasers == L_IN)       state_n = IN3;
                else if (lasers == L_OUT) state_n = IN1;
                else if (lasers == L_NONE) begin
                    back_n  = 1'b1;
                    state_n = T_IDLE;
                end
            end
            IN3: begin
                if (lasers == L_BOTH)     state_n = IN2;
                else if (lasers == L_NONE) begin
                    done_in_n = 1'b1;
                    state_n   = T_IDLE;
                end
            end
            OUT1: begin
                if (lasers == L_BOTH)     state_n = OUT2;
                else if (lasers == L_NONE) begin
                    back_n  = 1'b1;
                    state_n = T_IDLE;
                end
            end
            OUT2: begin
                if (lasers == L_OUT)      state_n = OUT3;
                else if (lasers == L_IN)  state_n = OUT1;
                else if (lasers == L_NONE) begin
                    back_n  = 1'b1;
                    state_n = T_IDLE;
                end
            end
            OUT3: begin
                if (lasers == L_BOTH)     state_n = OUT2;
                else if (lasers == L_NONE) begin
                    done_out_n = 1'b1;
                    state_n    = T_IDLE;
                end
            end
            default: state_n = T_IDLE;
        endcase
    end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Round-robin owner of the shared barrier gate: grants entry/exit lanes,
// tracks the pass via the laser tracker and keeps the occupancy count.
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY     = 20,
    parameter int unsigned OPEN_TIMEOUT = 1000,
    parameter int unsigned CLOSE_CYC    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic [1:0]       lasers,
    output logic             gate_open,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             car_in,
    output logic             car_out,
    output logic             abort,
    output logic             timeout_err,
    output logic             intrusion
);

    localparam int unsigned TMR_W = $clog2(OPEN_TIMEOUT + CLOSE_CYC + 1);

    ctrl_state_t      state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [CNT_W-1:0] count_n;
    logic [1:0]       lasers_q, grant_n;
    logic             last_exit, last_exit_n;
    logic             gate_open_n, full_n;
    logic             car_in_n, car_out_n, abort_n, timeout_n, intrusion_n;
    logic             done_in, done_out, back;
    logic             entry_ok, exit_ok, lasers_still;

    laser_seq_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .lasers   (lasers),
        .done_in  (done_in),
        .done_out (done_out),
        .back     (back)
    );

    assign entry_ok     = entry_req & ~full;
    assign exit_ok      = exit_req;
    assign lasers_still = (lasers == lasers_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            count       <= '0;
            full        <= 1'b0;
            lasers_q    <= L_NONE;
            last_exit   <= 1'b1;
            gate_open   <= 1'b0;
            grant       <= 2'b00;
            car_in      <= 1'b0;
            car_out     <= 1'b0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
            intrusion   <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            count       <= count_n;
            full        <= full_n;
            lasers_q    <= lasers;
            last_exit   <= last_exit_n;
            gate_open   <= gate_open_n;
            grant       <= grant_n;
            car_in      <= car_in_n;
            car_out     <= car_out_n;
            abort       <= abort_n;
            timeout_err <= timeout_n;
            intrusion   <= intrusion_n;
        end
    end

    // Timer counts idle-laser cycles while open and hold-off cycles while closed.
    always_comb begin
        state_n     = state;
        timer_n     = timer;
        count_n     = count;
        last_exit_n = last_exit;
        car_in_n    = 1'b0;
        car_out_n   = 1'b0;
        abort_n     = 1'b0;
        timeout_n   = 1'b0;
        intrusion_n = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (done_in || done_out) intrusion_n = 1'b1;
                if (entry_ok && (!exit_ok || last_exit)) begin
                    state_n     = OPEN_IN;
                    last_exit_n = 1'b0;
                end else if (exit_ok) begin
                    state_n     = OPEN_OUT;
                    last_exit_n = 1'b1;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                timer_n = lasers_still ? timer + TMR_W'(1) : '0;
                if (state == OPEN_IN && done_in) begin
                    count_n  = count + CNT_W'(1);
                    car_in_n = 1'b1;
                    state_n  = CLOSE;
                end else if (state == OPEN_OUT && done_out) begin
                    count_n   = (count == '0) ? count : count - CNT_W'(1);
                    car_out_n = 1'b1;
                    state_n   = CLOSE;
                end else if (back || done_in || done_out) begin
                    abort_n = 1'b1;
                    state_n = CLOSE;
                end else if (lasers_still && timer == TMR_W'(OPEN_TIMEOUT - 1)) begin
                    timeout_n = 1'b1;
                    state_n   = CLOSE;
                end
                if (state_n == CLOSE) timer_n = '0;
            end
            CLOSE: begin
                if (timer == TMR_W'(CLOSE_CYC - 1)) begin
                    state_n = IDLE;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        gate_open_n = (state_n == OPEN_IN) || (state_n == OPEN_OUT);
        grant_n     = {state_n == OPEN_OUT, state_n == OPEN_IN};
        full_n      = (count_n == CNT_W'(CAPACITY));
    end

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler with CAPACITY=3, OPEN_TIMEOUT=16, CLOSE_CYC=4.
module tb_parking_gate_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic [1:0] lasers = 2'b00;
    logic       gate_open;
    logic [1:0] grant;
    logic [6:0] count;
    logic       full, car_in, car_out, abort, timeout_err, intrusion;

    int total = 0;
    int bad = 0;
    int n_in = 0, n_out = 0, n_abort = 0, n_to = 0, n_intr = 0;

    parking_gate_scheduler #(
        .CAPACITY     (3),
        .OPEN_TIMEOUT (16),
        .CLOSE_CYC    (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .lasers      (lasers),
        .gate_open   (gate_open),
        .grant       (grant),
        .count       (count),
        .full        (full),
        .car_in      (car_in),
        .car_out     (car_out),
        .abort       (abort),
        .timeout_err (timeout_err),
        .intrusion   (intrusion)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (car_in === 1'b1)      n_in++;
        if (car_out === 1'b1)     n_out++;
        if (abort === 1'b1)       n_abort++;
        if (timeout_err === 1'b1) n_to++;
        if (intrusion === 1'b1)   n_intr++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply(input logic [1:0] code);
        lasers = code;
        tick(3);
    endtask

    task automatic pass_in();
        apply(2'b01); apply(2'b11); apply(2'b10); apply(2'b00);
    endtask

    task automatic pass_out();
        apply(2'b10); apply(2'b11); apply(2'b01); apply(2'b00);
    endtask

    task automatic wait_gate(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (gate_open === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick(2);
        total++; if (gate_open !== 1'b0) begin bad++; $display("FAIL reset_gate: got %b want 0", gate_open); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if (count !== 7'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
        total++; if ({full, car_in, car_out, abort, timeout_err, intrusion} !== 6'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000000", {full, car_in, car_out, abort, timeout_err, intrusion});
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_entry_pass();
        int in0;
        in0 = n_in;
        entry_req = 1'b1;
        tick(1);
        total++; if (grant !== 2'b01) begin bad++; $display("FAIL entry_grant: got %b want 01", grant); end
        total++; if (gate_open !== 1'b1) begin bad++; $display("FAIL entry_gate_open: got %b want 1", gate_open); end
        entry_req = 1'b0;
        pass_in();
        total++; if (n_in - in0 !== 1) begin bad++; $display("FAIL entry_car_in: got %0d want 1", n_in - in0); end
        total++; if (count !== 7'd1) begin bad++; $display("FAIL entry_count: got %0d want 1", count); end
        total++; if (gate_open !== 1'b0 || grant !== 2'b00) begin
            bad++; $display("FAIL entry_closed: got gate=%b grant=%b want gate=0 grant=00", gate_open, grant);
        end
        entry_req = 1'b1;
        tick(3);
        total++; if (gate_open !== 1'b0) begin bad++; $display("FAIL close_hold: got %b want 0", gate_open); end
        tick(1);
        total++; if (gate_open !== 1'b1 || grant !== 2'b01) begin
            bad++; $display("FAIL close_release: got gate=%b grant=%b want gate=1 grant=01", gate_open, grant);
        end
        entry_req = 1'b0;
    endtask

    task automatic test_fill();
        logic ok;
        int out0;
        pass_in();
        total++; if (count !== 7'd2) begin bad++; $display("FAIL fill_count2: got %0d want 2", count); end
        entry_req = 1'b1;
        wait_gate(ok);
        total++; if (!ok) begin bad++; $display("FAIL fill_grant3: got no grant want grant"); end
        entry_req = 1'b0;
        pass_in();
        total++; if (count !== 7'd3 || full !== 1'b1) begin
            bad++; $display("FAIL fill_full: got count=%0d full=%b want count=3 full=1", count, full);
        end
        entry_req = 1'b1;
        tick(10);
        total++; if (gate_open !== 1'b0 || grant !== 2'b00) begin
            bad++; $display("FAIL full_blocks_entry: got gate=%b grant=%b want gate=0 grant=00", gate_open, grant);
        end
        exit_req = 1'b1;
        wait_gate(ok);
        total++; if (!ok || grant !== 2'b10) begin bad++; $display("FAIL exit_grant: got %b want 10", grant); end
        exit_req  = 1'b0;
        entry_req = 1'b0;
        out0 = n_out;
        pass_out();
        total++; if (n_out - out0 !== 1) begin bad++; $display("FAIL exit_car_out: got %0d want 1", n_out - out0); end
        total++; if (count !== 7'd2 || full !== 1'b0) begin
            bad++; $display("FAIL exit_count: got count=%0d full=%b want count=2 full=0", count, full);
        end
    endtask

    task automatic test_round_robin();
        logic ok;
        rst = 1'b1;
        tick(1);
        total++; if (count !== 7'd0 || gate_open !== 1'b0) begin
            bad++; $display("FAIL rr_reset: got count=%0d gate=%b want count=0 gate=0", count, gate_open);
        end
        rst = 1'b0;
        entry_req = 1'b1;
        exit_req  = 1'b1;
        wait_gate(ok);
        total++; if (!ok || grant !== 2'b01) begin bad++; $display("FAIL rr_first: got %b want 01", grant); end
        pass_in();
        wait_gate(ok);
        total++; if (!ok || grant !== 2'b10) begin bad++; $display("FAIL rr_second: got %b want 10", grant); end
        pass_out();
        wait_gate(ok);
        total++; if (!ok || grant !== 2'b01) begin bad++; $display("FAIL rr_third: got %b want 01", grant); end
        entry_req = 1'b0;
        exit_req  = 1'b0;
        pass_in();
        total++; if (count !== 7'd1) begin bad++; $display("FAIL rr_count: got %0d want 1", count); end
    endtask

    task automatic test_abort();
        logic ok;
        int ab0, in0;
        entry_req = 1'b1;
        wait_gate(ok);
        total++; if (!ok || grant !== 2'b01) begin bad++; $display("FAIL abort_entry_grant: got %b want 01", grant); end
        entry_req = 1'b0;
        ab0 = n_abort;
        apply(2'b01); apply(2'b11); apply(2'b01); apply(2'b00);
        total++; if (n_abort - ab0 !== 1) begin bad++; $display("FAIL abort_backout: got %0d want 1", n_abort - ab0); end
        total++; if (count !== 7'd1 || gate_open !== 1'b0) begin
            bad++; $display("FAIL abort_backout_state: got count=%0d gate=%b want count=1 gate=0", count, gate_open);
        end
        exit_req = 1'b1;
        wait_gate(ok);
        total++; if (!ok || grant !== 2'b10) begin bad++; $display("FAIL abort_exit_grant: got %b want 10", grant); end
        exit_req = 1'b0;
        ab0 = n_abort;
        in0 = n_in;
        pass_in();
        total++; if (n_abort - ab0 !== 1 || n_in - in0 !== 0) begin
            bad++; $display("FAIL abort_wrong_dir: got abort=%0d car_in=%0d want abort=1 car_in=0", n_abort - ab0, n_in - in0);
        end
        total++; if (count !== 7'd1) begin bad++; $display("FAIL abort_wrong_dir_count: got %0d want 1", count); end
    endtask

    task automatic test_timeout();
        logic ok;
        int to0;
        to0 = n_to;
        entry_req = 1'b1;
        wait_gate(ok);
        entry_req = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL timeout_grant: got no grant want grant"); end
        tick(15);
        total++; if (gate_open !== 1'b1 || n_to - to0 !== 0) begin
            bad++; $display("FAIL timeout_early: got gate=%b pulses=%0d want gate=1 pulses=0", gate_open, n_to - to0);
        end
        tick(1);
        total++; if (timeout_err !== 1'b1 || gate_open !== 1'b0) begin
            bad++; $display("FAIL timeout_fire: got err=%b gate=%b want err=1 gate=0", timeout_err, gate_open);
        end
        total++; if (count !== 7'd1) begin bad++; $display("FAIL timeout_count: got %0d want 1", count); end
    endtask

    task automatic test_intrusion();
        int ir0;
        tick(6);
        ir0 = n_intr;
        pass_in();
        total++; if (n_intr - ir0 !== 1) begin bad++; $display("FAIL intrusion_pulse: got %0d want 1", n_intr - ir0); end
        total++; if (count !== 7'd1 || gate_open !== 1'b0) begin
            bad++; $display("FAIL intrusion_state: got count=%0d gate=%b want count=1 gate=0", count, gate_open);
        end
    endtask

    task automatic test_reset_mid_pass();
        logic ok;
        entry_req = 1'b1;
        wait_gate(ok);
        entry_req = 1'b0;
        lasers = 2'b01;
        tick(2);
        total++; if (!ok || count !== 7'd1) begin bad++; $display("FAIL midrst_pre: got count=%0d want 1", count); end
        #3;
        rst = 1'b1;
        #1;
        total++; if (gate_open !== 1'b0 || grant !== 2'b00 || count !== 7'd0) begin
            bad++; $display("FAIL midrst_async: got gate=%b grant=%b count=%0d want 0 00 0", gate_open, grant, count);
        end
        lasers = 2'b00;
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_entry_pass();
        test_fill();
        test_round_robin();
        test_abort();
        test_timeout();
        test_intrusion();
        test_reset_mid_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
